apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer_if.sv | 22 ++
 rtl/apb_timer.sv | 199 +++++++++++++++++++
 tb/tb_apb_timer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_if.sv
// APB requester/completer signal bundle for the machine timer.
// The master modport drives the request side; the slave modport drives the response.
interface apb_timer_if;
  logic        APB_psel;
  logic        APB_penable;
  logic        APB_pwrite;
  logic [31:0] APB_paddr;
  logic [31:0] APB_pwdata;
  logic [31:0] APB_prdata;
  logic        APB_pready;
  logic        APB_perr;

  modport master (
    output APB_psel, APB_penable, APB_pwrite, APB_paddr, APB_pwdata,
    input  APB_prdata, APB_pready, APB_perr
  );

  modport slave (
    input  APB_psel, APB_penable, APB_pwrite, APB_paddr, APB_pwdata,
    output APB_prdata, APB_pready, APB_perr
  );
endinterface

// File: rtl/apb_timer.sv
// APB machine timer: 64-bit mtime with prescaler, mtimecmp compare and level interrupt.
// Responder FSM with configurable wait states; MTIME_HI reads return a shadow captured by the LO read.
module apb_timer #(
  parameter bit          HAS_PENABLE = 1'b1,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       APB_PCLK,
  input  logic       APB_PRESET,
  apb_timer_if.slave apb,
  output logic       interrupt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        write_q, write_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pready_q, pready_d;
  logic        perr_q, perr_d;
  logic [31:0] prdata_q, prdata_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  presc_cnt_q, presc_cnt_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [7:0]  presc_q, presc_d;
  logic        match_q, match_d;
  logic        irq_q, irq_d;

  logic        access;
  logic        enter_resp;
  logic [4:0]  sel_addr;
  logic        sel_write;
  logic        sel_err;
  logic [31:0] rd_val;
  logic        commit;
  logic        addr_unused;

  assign addr_unused = ^apb.APB_paddr[31:5];
  assign access      = apb.APB_psel && (apb.APB_penable || !HAS_PENABLE);

  // With zero wait states RESP is entered straight from cycle A, so the
  // decode must look at the live bus rather than the latched copy.
  always_comb begin
    sel_addr  = (state_q == IDLE) ? apb.APB_paddr[4:0] : addr_q;
    sel_write = (state_q == IDLE) ? apb.APB_pwrite : write_q;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[4:2] > 3'd5);
    case (sel_addr[4:2])
      3'd0:    rd_val = mtime_q[31:0];
      3'd1:    rd_val = shadow_q;
      3'd2:    rd_val = mtimecmp_q[31:0];
      3'd3:    rd_val = mtimecmp_q[63:32];
      3'd4:    rd_val = {16'h0000, presc_q, 6'b000000, ie_q, en_q};
      3'd5:    rd_val = {31'h0, match_q};
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          write_d = apb.APB_pwrite;
          addr_d  = apb.APB_paddr[4:0];
          wdata_d = apb.APB_pwdata;
          if (WS == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WS;
          end
        end
      end
      WAIT: begin
        if (!apb.APB_psel) begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == 4'd1) begin
          state_d    = RESP;
          wait_cnt_d = 4'd0;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pready_d = enter_resp;
    perr_d   = enter_resp && sel_err;
    prdata_d = 32'h0;
    shadow_d = shadow_q;
    if (enter_resp && !sel_err && !sel_write) begin
      prdata_d = rd_val;
      if (sel_addr[4:2] == 3'd0) begin
        shadow_d = mtime_q[63:32];
      end
    end
  end

  assign commit = (state_q == RESP) && write_q &&
                  (addr_q[1:0] == 2'b00) && (addr_q[4:2] <= 3'd5);

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    presc_cnt_d = presc_cnt_q;
    en_d        = en_q;
    ie_d        = ie_q;
    presc_d     = presc_q;
    if (en_q) begin
      if (presc_cnt_q == presc_q) begin
        mtime_d     = mtime_q + 64'd1;
        presc_cnt_d = 8'd0;
      end else begin
        presc_cnt_d = presc_cnt_q + 8'd1;
      end
    end
    // A bus write to mtime overrides the tick of the same cycle.
    if (commit) begin
      case (addr_q[4:2])
        3'd0: mtime_d = {mtime_q[63:32], wdata_q};
        3'd1: mtime_d = {wdata_q, mtime_q[31:0]};
        3'd2: mtimecmp_d = {mtimecmp_q[63:32], wdata_q};
        3'd3: mtimecmp_d = {wdata_q, mtimecmp_q[31:0]};
        3'd4: begin
          en_d        = wdata_q[0];
          ie_d        = wdata_q[1];
          presc_d     = wdata_q[15:8];
          presc_cnt_d = 8'd0;
        end
        default: ;
      endcase
    end
    match_d = (mtime_q >= mtimecmp_q);
    irq_d   = match_q && ie_q;
  end

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 5'd0;
      wdata_q     <= 32'h0;
      pready_q    <= 1'b0;
      perr_q      <= 1'b0;
      prdata_q    <= 32'h0;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q    <= 32'h0;
      presc_cnt_q <= 8'd0;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      presc_q     <= 8'd0;
      match_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      perr_q      <= perr_d;
      prdata_q    <= prdata_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      shadow_q    <= shadow_d;
      presc_cnt_q <= presc_cnt_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      presc_q     <= presc_d;
      match_q     <= match_d;
      irq_q       <= irq_d;
    end
  end

  assign apb.APB_pready = pready_q;
  assign apb.APB_perr   = perr_q;
  assign apb.APB_prdata = prdata_q;
  assign interrupt      = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: three instances (two-phase WS=1, two-phase WS=3,
// single-phase WS=0) driven by a table of register accesses plus corner-case sequences.
module tb_apb_timer;

  logic        clk = 1'b0;
  logic        rst     [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] rdata_w [3];
  logic [2:0]  ready_w;
  logic [2:0]  perr_w;
  logic [2:0]  irq_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_timer_if bus0 ();
  apb_timer_if bus1 ();
  apb_timer_if bus2 ();

  assign bus0.APB_psel = psel[0];  assign bus0.APB_penable = penable[0];
  assign bus0.APB_pwrite = pwrite[0];  assign bus0.APB_paddr = paddr[0];
  assign bus0.APB_pwdata = pwdata[0];
  assign bus1.APB_psel = psel[1];  assign bus1.APB_penable = penable[1];
  assign bus1.APB_pwrite = pwrite[1];  assign bus1.APB_paddr = paddr[1];
  assign bus1.APB_pwdata = pwdata[1];
  assign bus2.APB_psel = psel[2];  assign bus2.APB_penable = penable[2];
  assign bus2.APB_pwrite = pwrite[2];  assign bus2.APB_paddr = paddr[2];
  assign bus2.APB_pwdata = pwdata[2];

  assign rdata_w[0] = bus0.APB_prdata;
  assign rdata_w[1] = bus1.APB_prdata;
  assign rdata_w[2] = bus2.APB_prdata;
  assign ready_w = {bus2.APB_pready, bus1.APB_pready, bus0.APB_pready};
  assign perr_w  = {bus2.APB_perr, bus1.APB_perr, bus0.APB_perr};

  apb_timer #(.HAS_PENABLE(1'b1), .WAIT_STATES(1)) dut0 (
    .APB_PCLK(clk), .APB_PRESET(rst[0]), .apb(bus0), .interrupt(irq_w[0]));
  apb_timer #(.HAS_PENABLE(1'b1), .WAIT_STATES(3)) dut1 (
    .APB_PCLK(clk), .APB_PRESET(rst[1]), .apb(bus1), .interrupt(irq_w[1]));
  apb_timer #(.HAS_PENABLE(1'b0), .WAIT_STATES(0)) dut2 (
    .APB_PCLK(clk), .APB_PRESET(rst[2]), .apb(bus2), .interrupt(irq_w[2]));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One APB transfer; request inputs are scrambled after cycle A to show they are latched.
  task automatic apb(input int k, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat);
    bit done;
    done = 0; lat = 0; rdata = 32'h0; err = 1'b0;
    @(posedge clk); #1;
    psel[k] = 1'b1; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wdata; penable[k] = 1'b0;
    if (k != 2) begin
      @(posedge clk); #1;
      penable[k] = 1'b1;
    end
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (ready_w[k]) begin
        done = 1; lat = n; rdata = rdata_w[k]; err = perr_w[k];
      end else begin
        paddr[k] = ~addr; pwdata[k] = ~wdata; pwrite[k] = ~wr;
      end
    end
    psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
    if (!done) chk("pready_timeout", 64'd0, 64'd1);
    $display("dut%0d %s addr=%08h wdata=%08h rdata=%08h perr=%0d lat=%0d",
             k, wr ? "WR" : "RD", addr, wdata, rdata, err, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, v1, v2;
    logic        er;
    int          lat, cnt;
    logic [3:0]  pat;
    bit          done;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = 32'h0; pwdata[k] = 32'h0;
    end
    cyc(3);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    cyc(1);
    chk("rst_pready", {61'h0, ready_w}, 64'h0);
    chk("rst_perr", {61'h0, perr_w}, 64'h0);
    chk("rst_irq", {61'h0, irq_w}, 64'h0);
    chk("rst_prdata", {rdata_w[0], rdata_w[1]}, 64'h0);

    add(0, 32'h10, 0, 32'h0000_0000, 0, "ctrl_rst");
    add(0, 32'h08, 0, 32'hFFFF_FFFF, 0, "cmplo_rst");
    add(0, 32'h0C, 0, 32'hFFFF_FFFF, 0, "cmphi_rst");
    add(0, 32'h00, 0, 32'h0000_0000, 0, "mtlo_rst");
    add(0, 32'h04, 0, 32'h0000_0000, 0, "mthi_rst");
    add(0, 32'h14, 0, 32'h0000_0000, 0, "status_rst");
    add(0, 32'h18, 0, 32'h0000_0000, 1, "err_rd18");
    add(0, 32'h1C, 0, 32'h0000_0000, 1, "err_rd1c");
    add(1, 32'h01, 32'h3, 32'h0, 1, "err_wr01");
    add(0, 32'h00, 0, 32'h0000_0000, 0, "mtlo_after_err");
    add(1, 32'h10, 32'hFFFF_FF02, 32'h0, 0, "wr_ctrl");
    add(0, 32'h10, 0, 32'h0000_FF02, 0, "rd_ctrl");
    add(0, 32'hFFFF_FF10, 0, 32'h0000_FF02, 0, "rd_ctrl_alias");
    add(1, 32'h14, 32'hFFFF_FFFF, 32'h0, 0, "wr_status");
    add(0, 32'h14, 0, 32'h0000_0000, 0, "rd_status");
    add(1, 32'h08, 32'hAAAA_5555, 32'h0, 0, "wr_cmplo");
    add(0, 32'h08, 0, 32'hAAAA_5555, 0, "rd_cmplo");
    add(1, 32'h0C, 32'h1234_5678, 32'h0, 0, "wr_cmphi");
    add(0, 32'h0C, 0, 32'h1234_5678, 0, "rd_cmphi");
    add(1, 32'h04, 32'h0000_DEAD, 32'h0, 0, "wr_mthi");
    add(1, 32'h00, 32'h0000_0007, 32'h0, 0, "wr_mtlo");
    add(0, 32'h00, 0, 32'h0000_0007, 0, "rd_mtlo");
    add(0, 32'h04, 0, 32'h0000_DEAD, 0, "rd_mthi_shadow");
    add(0, 32'h03, 0, 32'h0000_0000, 1, "err_rd03");
    add(1, 32'h10, 32'h0, 32'h0, 0, "wr_ctrl0");
    add(0, 32'h10, 0, 32'h0000_0000, 0, "rd_ctrl0");

    foreach (vecs[i]) begin
      apb(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_perr"}, {63'h0, er}, {63'h0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, lat, 64'd2);
      if (!vecs[i].wr || vecs[i].exp_err)
        chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
    end
    chk("table_irq", {63'h0, irq_w[0]}, 64'h0);

    // Counting from zero with EN=1.
    apb(0, 1, 32'h04, 32'h0, rd, er, lat);
    apb(0, 1, 32'h00, 32'h0, rd, er, lat);
    apb(0, 1, 32'h10, 32'h1, rd, er, lat);
    chk("en_wr_lat", lat, 64'd2);
    chk("en_wr_perr", {63'h0, er}, 64'h0);
    cyc(10);
    apb(0, 0, 32'h00, 0, v1, er, lat);
    chk("count_nonzero", {63'h0, v1 != 0}, 64'h1);
    apb(0, 0, 32'h00, 0, v2, er, lat);
    chk("count_rises", {63'h0, v2 > v1}, 64'h1);

    // Compare match and interrupt timing.
    apb(0, 1, 32'h10, 32'h0, rd, er, lat);
    apb(0, 1, 32'h00, 32'h0, rd, er, lat);
    apb(0, 1, 32'h0C, 32'h0, rd, er, lat);
    apb(0, 1, 32'h08, 32'h5, rd, er, lat);
    chk("irq_before_en", {63'h0, irq_w[0]}, 64'h0);
    apb(0, 1, 32'h10, 32'h3, rd, er, lat);
    cyc(7);
    chk("irq_c6_low", {63'h0, irq_w[0]}, 64'h0);
    cyc(1);
    chk("irq_c7_high", {63'h0, irq_w[0]}, 64'h1);
    apb(0, 0, 32'h14, 0, rd, er, lat);
    chk("status_match", rd, 64'h1);
    apb(0, 1, 32'h08, 32'h100, rd, er, lat);
    cyc(3);
    chk("irq_cleared", {63'h0, irq_w[0]}, 64'h0);

    // Error accesses leave registers alone.
    apb(0, 1, 32'h10, 32'h0, rd, er, lat);
    apb(0, 0, 32'h00, 0, v1, er, lat);
    apb(0, 1, 32'h02, 32'h1234_5678, rd, er, lat);
    chk("err_wr02_perr", {63'h0, er}, 64'h1);
    chk("err_wr02_rdata", rd, 64'h0);
    apb(0, 0, 32'h00, 0, rd, er, lat);
    chk("err_wr02_nochange", rd, v1);
    apb(0, 0, 32'h18, 0, rd, er, lat);
    chk("err_rd18b_perr", {63'h0, er}, 64'h1);
    chk("err_rd18b_rdata", rd, 64'h0);

    // Reset in the RESP cycle of an MTIMECMP_LO write.
    @(posedge clk); #1;
    psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h08; pwdata[0] = 32'h55; penable[0] = 1'b0;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
      if (ready_w[0]) done = 1;
    end
    chk("rstresp_reached", {63'h0, done}, 64'h1);
    rst[0] = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0; pwrite[0] = 1'b0;
    cyc(1);
    rst[0] = 1'b0;
    chk("rstresp_pready", {63'h0, ready_w[0]}, 64'h0);
    chk("rstresp_perr", {63'h0, perr_w[0]}, 64'h0);
    chk("rstresp_prdata", rdata_w[0], 64'h0);
    chk("rstresp_irq", {63'h0, irq_w[0]}, 64'h0);
    apb(0, 0, 32'h08, 0, rd, er, lat);
    chk("rstresp_cmplo", rd, 64'hFFFF_FFFF);
    apb(0, 0, 32'h0C, 0, rd, er, lat);
    chk("rstresp_cmphi", rd, 64'hFFFF_FFFF);
    apb(0, 0, 32'h10, 0, rd, er, lat);
    chk("rstresp_ctrl", rd, 64'h0);
    apb(0, 0, 32'h00, 0, rd, er, lat);
    chk("rstresp_mtlo", rd, 64'h0);
    apb(0, 0, 32'h04, 0, rd, er, lat);
    chk("rstresp_mthi", rd, 64'h0);

    // Three wait states: abort a CTRL write by dropping psel in WAIT.
    apb(1, 0, 32'h10, 0, rd, er, lat);
    chk("ws3_rd_lat", lat, 64'd4);
    chk("ws3_rd_ctrl", rd, 64'h0);
    @(posedge clk); #1;
    psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'h3; penable[1] = 1'b0;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    cnt = ready_w[1] ? 1 : 0;
    psel[1] = 1'b0; penable[1] = 1'b0; pwrite[1] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ready_w[1]) cnt++;
    end
    chk("abort_no_pready", cnt, 64'd0);
    apb(1, 0, 32'h10, 0, rd, er, lat);
    chk("abort_ctrl_unchanged", rd, 64'h0);
    apb(1, 1, 32'h10, 32'h3, rd, er, lat);
    chk("ws3_wr_lat", lat, 64'd4);
    apb(1, 0, 32'h10, 0, rd, er, lat);
    chk("ws3_ctrl_written", rd, 64'h3);

    // Single-phase, zero wait states: atomic 64-bit read across the LO wrap.
    apb(2, 1, 32'h10, 32'h1, rd, er, lat);
    chk("ws0_wr_lat", lat, 64'd1);
    apb(2, 1, 32'h04, 32'h0, rd, er, lat);
    apb(2, 1, 32'h00, 32'hFFFF_FFFE, rd, er, lat);
    apb(2, 0, 32'h00, 0, v1, er, lat);
    chk("atomic_lo", v1, 64'hFFFF_FFFE);
    apb(2, 0, 32'h04, 0, v2, er, lat);
    chk("atomic_hi_shadow", v2, 64'h0);
    apb(2, 0, 32'h00, 0, v1, er, lat);
    apb(2, 0, 32'h04, 0, v2, er, lat);
    chk("atomic_hi_after_wrap", v2, 64'h1);

    // Back-to-back reads with psel held high.
    @(posedge clk); #1;
    psel[2] = 1'b1; pwrite[2] = 1'b0; paddr[2] = 32'h10; penable[2] = 1'b0;
    pat[0] = ready_w[2];
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ready_w[2];
      if (i == 1) chk("b2b_rdata", rdata_w[2], 64'h1);
    end
    psel[2] = 1'b0;
    $display("dut2 RD b2b addr=00000010 pready_pattern=%b", pat);
    chk("b2b_pattern", {60'h0, pat}, 64'hA);
    cnt = 0;
    for (int i = 0; i < 4; i++) if (pat[i]) cnt++;
    chk("b2b_pulses", cnt, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
